// File: rtl/ddr3_lane_read_training_ctrl.sv
// rtl/ddr3_lane_read_training_ctrl.sv - DDR3 byte-lane read-training sweep and centring engine (optional READ_TRAIN_EYE_MON_EN)
module ddr3_lane_read_training_ctrl #(
    parameter int          TAP_W         = 8,
    parameter int          MAX_TAPS      = 128,
    parameter int          SETTLE_CYCLES = 8,
    parameter int          SAMPLE_CYCLES = 16,
    parameter int          MIN_WINDOW    = 4,
    parameter logic [7:0]  PATTERN       = 8'h55
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             START,
    input  logic             DATA_VALID,
    input  logic [7:0]       RX_DATA_0,
    input  logic             EYE_MONITOR_EARLY_0,
    input  logic             EYE_MONITOR_LATE_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0,
    output logic             DELAY_LINE_LOAD_0,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             EYE_MONITOR_CLEAR_FLAGS_0,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [TAP_W-1:0] TAP_OUT
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(MAX_TAPS - 1);
    localparam logic [TAP_W:0]   MIN_W       = (TAP_W + 1)'(MIN_WINDOW);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_STEP,
        S_BACK, S_BMOVE, S_BSETTLE, S_DONE, S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] first_q, first_d;
    logic [TAP_W-1:0] last_q, last_d;
    logic [TAP_W-1:0] centre_q, centre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             win_q, win_d;
    logic             bad_q, bad_d;
    logic             seen_q, seen_d;

    logic             eye_bad;
    logic             beat_bad;
    logic             tap_fail;
    logic [TAP_W:0]   width;
    logic [TAP_W-1:0] centre;

`ifdef READ_TRAIN_EYE_MON_EN
    assign eye_bad                   = EYE_MONITOR_EARLY_0 | EYE_MONITOR_LATE_0;
    assign EYE_MONITOR_CLEAR_FLAGS_0 = (state_q == S_CLEAR);
`else
    logic unused_eye_flags;
    assign unused_eye_flags          = EYE_MONITOR_EARLY_0 ^ EYE_MONITOR_LATE_0;
    assign eye_bad                   = 1'b0;
    assign EYE_MONITOR_CLEAR_FLAGS_0 = 1'b0;
`endif

    // A tap also fails if no read beat at all arrived during its sample window.
    assign beat_bad = DATA_VALID && (RX_DATA_0 != PATTERN);
    assign tap_fail = bad_q | beat_bad | eye_bad | ~(seen_q | DATA_VALID);
    assign width    = {1'b0, last_q} - {1'b0, first_q} + 1'b1;
    assign centre   = first_q + ((last_q - first_q) >> 1);

    assign DELAY_LINE_LOAD_0      = (state_q == S_LOAD);
    assign DELAY_LINE_MOVE_0      = (state_q == S_STEP) || (state_q == S_BMOVE);
    // Direction flips only on entry to/exit from the sweep, never on a MOVE cycle.
    assign DELAY_LINE_DIRECTION_0 = state_q inside {S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_STEP};
    assign BUSY                   = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
    assign DONE                   = (state_q == S_DONE);
    assign FAIL                   = (state_q == S_FAIL);
    assign TAP_OUT                = tap_q;

    // State and datapath registers.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            first_q  <= '0;
            last_q   <= '0;
            centre_q <= '0;
            cnt_q    <= '0;
            win_q    <= 1'b0;
            bad_q    <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            first_q  <= first_d;
            last_q   <= last_d;
            centre_q <= centre_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            bad_q    <= bad_d;
            seen_q   <= seen_d;
        end
    end

    // Sweep, window tracking and back-off sequencing.
    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        first_d  = first_q;
        last_d   = last_q;
        centre_d = centre_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        bad_d    = bad_q;
        seen_d   = seen_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (START) begin
                    state_d = S_LOAD;
                    tap_d   = '0;
                    first_d = '0;
                    last_d  = '0;
                    win_d   = 1'b0;
                    bad_d   = 1'b0;
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                tap_d   = '0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    bad_d   = 1'b0;
                    seen_d  = 1'b0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                bad_d  = bad_q | beat_bad | eye_bad;
                seen_d = seen_q | DATA_VALID;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == SAMPLE_LAST) begin
                    if (!tap_fail) begin
                        if (!win_q) begin
                            first_d = tap_q;
                        end
                        last_d = tap_q;
                        win_d  = 1'b1;
                    end
                    if ((tap_fail && win_q) || DELAY_LINE_OUT_OF_RANGE_0 || (tap_q == TAP_LAST)) begin
                        state_d = S_BACK;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                tap_d   = tap_q + 1'b1;
                state_d = S_CLEAR;
            end
            S_BACK: begin
                if (!win_q || (width < MIN_W)) begin
                    state_d = S_FAIL;
                end else begin
                    centre_d = centre;
                    state_d  = (tap_q == centre) ? S_DONE : S_BMOVE;
                end
            end
            S_BMOVE: begin
                tap_d   = tap_q - 1'b1;
                cnt_d   = '0;
                state_d = S_BSETTLE;
            end
            S_BSETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = (tap_q == centre_q) ? S_DONE : S_BMOVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddr3_lane_read_training_ctrl.sv
// tb/tb_ddr3_lane_read_training_ctrl.sv - table-driven bench for ddr3_lane_read_training_ctrl
module tb_ddr3_lane_read_training_ctrl;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N;
    logic       START;
    logic       DATA_VALID;
    logic [7:0] RX_DATA_0;
    logic       EYE_MONITOR_EARLY_0;
    logic       EYE_MONITOR_LATE_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       EYE_MONITOR_CLEAR_FLAGS_0;
    logic       BUSY;
    logic       DONE;
    logic       FAIL;
    logic [7:0] TAP_OUT;

    ddr3_lane_read_training_ctrl dut (
        .FAB_CLK                   (FAB_CLK),
        .ARST_N                    (ARST_N),
        .START                     (START),
        .DATA_VALID                (DATA_VALID),
        .RX_DATA_0                 (RX_DATA_0),
        .EYE_MONITOR_EARLY_0       (EYE_MONITOR_EARLY_0),
        .EYE_MONITOR_LATE_0        (EYE_MONITOR_LATE_0),
        .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
        .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
        .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
        .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
        .EYE_MONITOR_CLEAR_FLAGS_0 (EYE_MONITOR_CLEAR_FLAGS_0),
        .BUSY                      (BUSY),
        .DONE                      (DONE),
        .FAIL                      (FAIL),
        .TAP_OUT                   (TAP_OUT)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct {
        int lo;
        int hi;
        int oor;
        int late;
        bit valid;
        int restart;
        bit e_done;
        bit e_fail;
        int e_tap;
        int e_up;
        int e_down;
        int e_cyc;
    } vec_t;

    vec_t tv[8];

    int n_cmp = 0;
    int n_bad = 0;

    // Delay-line model: its own tap, driven only by the DUT's LOAD/MOVE pulses.
    int tb_tap   = 0;
    int up_cnt   = 0;
    int down_cnt = 0;
    int load_cnt = 0;
    int clr_cnt  = 0;
    int viol_cnt = 0;
    logic prev_dir  = 1'b0;
    logic prev_move = 1'b0;
    logic prev_load = 1'b0;
    logic prev_clr  = 1'b0;

    int   win_lo   = 0;
    int   win_hi   = -1;
    int   oor_tap  = 999;
    int   late_tap = 999;
    logic valid_en = 1'b1;

    assign RX_DATA_0                 = (tb_tap >= win_lo && tb_tap <= win_hi) ? 8'h55 : 8'hA5;
    assign DATA_VALID                = valid_en;
    assign DELAY_LINE_OUT_OF_RANGE_0 = (tb_tap >= oor_tap);
    assign EYE_MONITOR_LATE_0        = (tb_tap == late_tap);
    assign EYE_MONITOR_EARLY_0       = 1'b0;

    // Track the delay line and watch pulse-protocol rules on every edge.
    always @(posedge FAB_CLK) begin
        if (ARST_N) begin
            if (DELAY_LINE_LOAD_0) begin
                tb_tap <= 0;
                load_cnt = load_cnt + 1;
            end else if (DELAY_LINE_MOVE_0) begin
                if (DELAY_LINE_DIRECTION_0) begin
                    tb_tap <= tb_tap + 1;
                    up_cnt = up_cnt + 1;
                end else begin
                    tb_tap <= tb_tap - 1;
                    down_cnt = down_cnt + 1;
                end
            end
            if (EYE_MONITOR_CLEAR_FLAGS_0) clr_cnt = clr_cnt + 1;
            if (DELAY_LINE_MOVE_0 && DELAY_LINE_LOAD_0) viol_cnt = viol_cnt + 1;
            if (DELAY_LINE_MOVE_0 && (DELAY_LINE_DIRECTION_0 != prev_dir)) viol_cnt = viol_cnt + 1;
            if ((DELAY_LINE_MOVE_0 && prev_move) || (DELAY_LINE_LOAD_0 && prev_load) ||
                (EYE_MONITOR_CLEAR_FLAGS_0 && prev_clr)) viol_cnt = viol_cnt + 1;
        end
        prev_dir  = DELAY_LINE_DIRECTION_0;
        prev_move = DELAY_LINE_MOVE_0;
        prev_load = DELAY_LINE_LOAD_0;
        prev_clr  = EYE_MONITOR_CLEAR_FLAGS_0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
                     EYE_MONITOR_CLEAR_FLAGS_0, BUSY, DONE, FAIL, TAP_OUT});
    endfunction

    task automatic run(input vec_t v, input int idx);
        int   b_up, b_dn, b_ld, b_clr, b_v, cyc, e_clr;
        logic load1;
        bit   timeout, busy_ok;
        win_lo   = v.lo;
        win_hi   = v.hi;
        oor_tap  = v.oor;
        late_tap = v.late;
        valid_en = v.valid;
        @(negedge FAB_CLK);
        b_up = up_cnt; b_dn = down_cnt; b_ld = load_cnt; b_clr = clr_cnt; b_v = viol_cnt;
        START   = 1'b1;
        cyc     = 0;
        load1   = 1'b0;
        timeout = 1'b0;
        busy_ok = 1'b1;
        while (1) begin
            @(posedge FAB_CLK);
            #1;
            cyc++;
            START = (v.restart != 0) && (cyc == v.restart);
            if (cyc == 1) load1 = DELAY_LINE_LOAD_0;
            if (DONE || FAIL) break;
            if (!BUSY) busy_ok = 1'b0;
            if (cyc >= 6000) begin
                timeout = 1'b1;
                break;
            end
        end
        START = 1'b0;
        check($sformatf("v%0d timeout", idx), int'(timeout), 0);
        check($sformatf("v%0d cycles", idx), cyc, v.e_cyc);
        check($sformatf("v%0d load_at_cycle1", idx), int'(load1), 1);
        check($sformatf("v%0d busy_during_run", idx), int'(busy_ok), 1);
        check($sformatf("v%0d done", idx), int'(DONE), int'(v.e_done));
        check($sformatf("v%0d fail", idx), int'(FAIL), int'(v.e_fail));
        check($sformatf("v%0d tap_out", idx), int'(TAP_OUT), v.e_tap);
        check($sformatf("v%0d model_tap", idx), tb_tap, v.e_tap);
        check($sformatf("v%0d up_moves", idx), up_cnt - b_up, v.e_up);
        check($sformatf("v%0d down_moves", idx), down_cnt - b_dn, v.e_down);
        check($sformatf("v%0d load_pulses", idx), load_cnt - b_ld, 1);
`ifdef READ_TRAIN_EYE_MON_EN
        e_clr = v.e_up + 1;
`else
        e_clr = 0;
`endif
        check($sformatf("v%0d clear_pulses", idx), clr_cnt - b_clr, e_clr);
        check($sformatf("v%0d protocol_violations", idx), viol_cnt - b_v, 0);
        repeat (3) @(posedge FAB_CLK);
        #1;
        check($sformatf("v%0d sticky_result", idx), int'({DONE, FAIL, BUSY}),
              int'({v.e_done, v.e_fail, 1'b0}));
    endtask

    initial begin
        int cyc;
        tv[0] = '{20, 40, 999, 999, 1'b1, 0, 1'b1, 1'b0, 30, 41, 11, 1193};
        tv[1] = '{200, 199, 999, 999, 1'b1, 0, 1'b0, 1'b1, 127, 127, 0, 3330};
        tv[2] = '{10, 12, 999, 999, 1'b1, 100, 1'b0, 1'b1, 13, 13, 0, 366};
        tv[3] = '{45, 60, 50, 999, 1'b1, 0, 1'b1, 1'b0, 47, 50, 3, 1355};
        tv[4] = '{0, 7, 999, 999, 1'b1, 0, 1'b1, 1'b0, 3, 8, 5, 281};
        tv[5] = '{120, 127, 999, 999, 1'b1, 0, 1'b1, 1'b0, 123, 127, 4, 3366};
`ifdef READ_TRAIN_EYE_MON_EN
        tv[6] = '{20, 40, 999, 35, 1'b1, 0, 1'b1, 1'b0, 27, 35, 8, 1010};
`else
        tv[6] = '{20, 40, 999, 35, 1'b1, 0, 1'b1, 1'b0, 30, 41, 11, 1193};
`endif
        tv[7] = '{0, 255, 999, 999, 1'b0, 0, 1'b0, 1'b1, 127, 127, 0, 3330};

        ARST_N = 1'b0;
        START  = 1'b0;
        repeat (2) @(posedge FAB_CLK);
        #1;
        check("reset outputs", out_vec(), 0);
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        @(posedge FAB_CLK);
        #1;
        check("idle after reset", out_vec(), 0);

        for (int i = 0; i < 8; i++) begin
            run(tv[i], i);
        end

        // Asynchronous reset in the middle of sampling tap 25.
        win_lo = 20; win_hi = 40; oor_tap = 999; late_tap = 999; valid_en = 1'b1;
        @(negedge FAB_CLK);
        START = 1'b1;
        @(negedge FAB_CLK);
        START = 1'b0;
        cyc = 0;
        while (tb_tap != 25 && cyc < 2000) begin
            @(negedge FAB_CLK);
            cyc++;
        end
        check("rst reach tap25", tb_tap, 25);
        repeat (14) @(negedge FAB_CLK);
        check("rst busy before", int'(BUSY), 1);
        #2;
        ARST_N = 1'b0;
        #1;
        check("rst outputs async", out_vec(), 0);
        @(posedge FAB_CLK);
        #1;
        check("rst outputs held", out_vec(), 0);
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        run(tv[0], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr3_lane_read_training_ctrl.md
# ddr3_lane_read_training_ctrl

Fabric-side read-training engine for one DDR3 byte lane. It sweeps the lane IOD's receive delay line from tap 0 upward and judges each tap on captured read data and, optionally, the eye-monitor flags. It then locates the first contiguous passing window and steps the delay line back to the window centre. It sits in the FAB_CLK domain and drives the IOD's delay-line and eye-monitor controls while the memory controller issues continuous MPR/pattern reads.

## Interface
- TAP_W, 8: width of tap counter and TAP_OUT.
- MAX_TAPS, 128: taps swept before the sweep is forced to end.
- SETTLE_CYCLES, 8: FAB_CLK cycles waited after any delay-line move, load or flag clear before sampling.
- SAMPLE_CYCLES, 16: FAB_CLK cycles per tap over which pass/fail is accumulated.
- MIN_WINDOW, 4: minimum passing-window width, in taps, for success.
- PATTERN, 8'h55: expected RX_DATA_0 value on every valid beat.
- FAB_CLK  input  1  fabric clock; all logic rising-edge.
- ARST_N  input  1  asynchronous active-low reset.
- START  input  1  level; training begins on the first cycle START=1 seen in IDLE.
- DATA_VALID  input  1  RX_DATA_0 holds a read beat this cycle.
- RX_DATA_0  input  8  deserialised read data from the lane IOD.
- EYE_MONITOR_EARLY_0  input  1  IOD early flag.
- EYE_MONITOR_LATE_0  input  1  IOD late flag.
- DELAY_LINE_OUT_OF_RANGE_0  input  1  delay line at its end stop.
- DELAY_LINE_LOAD_0  output  1  one-cycle pulse; resets the delay line to tap 0.
- DELAY_LINE_MOVE_0  output  1  one-cycle pulse; moves the delay line one tap.
- DELAY_LINE_DIRECTION_0  output  1  1 = increment, 0 = decrement; valid while MOVE=1.
- EYE_MONITOR_CLEAR_FLAGS_0  output  1  one-cycle pulse clearing the eye flags.
- BUSY  output  1  high in every state except IDLE, DONE and FAIL.
- DONE  output  1  sticky success.
- FAIL  output  1  sticky failure.
- TAP_OUT  output  TAP_W  current delay-line tap as tracked by the controller.

## Operation
- States: IDLE → LOAD → CLEAR → SETTLE → SAMPLE → (STEP → CLEAR … | BACK) → DONE/FAIL.
- IDLE/DONE/FAIL:
  - START=1 clears DONE, FAIL, tap, window registers and the pass flag, then enters LOAD.
- LOAD: pulses DELAY_LINE_LOAD_0 for one cycle; tap=0.
- CLEAR: pulses EYE_MONITOR_CLEAR_FLAGS_0 for one cycle.
- SETTLE: counts SETTLE_CYCLES cycles.
- SAMPLE: for SAMPLE_CYCLES cycles, the tap fails if any of the following occurs:
  - DATA_VALID=1 and RX_DATA_0≠PATTERN;
  - eye flag high (see Configuration);
  - zero valid beats seen over the whole window.
- After SAMPLE:
  - Tap passes with no window open: first=tap, last=tap, window open.
  - Tap passes with window open: last=tap.
  - Tap fails with window open: window closed → BACK.
  - DELAY_LINE_OUT_OF_RANGE_0=1, or tap=MAX_TAPS-1, also → BACK, keeping any open window as it stands.
  - Otherwise → STEP.
- STEP: pulses MOVE with DIRECTION=1; tap+1; then CLEAR.
- BACK:
  - Width = last-first+1.
  - If no window was found or width<MIN_WINDOW → FAIL; the tap is left where it is.
  - Else centre = first+((last-first)>>1), floor.
  - Issue tap-centre MOVE pulses with DIRECTION=0, each followed by SETTLE_CYCLES idle cycles; tap-1 per pulse.
  - Then → DONE.
- Arithmetic is unsigned TAP_W bits; MAX_TAPS ≤ 2^TAP_W is required.

## Timing
- Reset values:
  - All pulse outputs, BUSY, DONE and FAIL are 0.
  - TAP_OUT=0; state IDLE.
- START to LOAD pulse: 1 cycle.
- Each control pulse is exactly 1 cycle wide; MOVE and LOAD are never asserted in the same cycle.
- DIRECTION changes only in cycles where MOVE=0.
- Per-tap cost: 1 (CLEAR) + SETTLE_CYCLES + SAMPLE_CYCLES + 1 (STEP).
- DONE or FAIL rises 1 cycle after the last BACK settle, or after the BACK decision for a failure. It holds until the next START or reset.
- START while BUSY is ignored.
- ARST_N low mid-operation immediately returns everything to reset values; no delay-line move completes.

## Configuration
- READ_TRAIN_EYE_MON_EN defined:
  - EYE_MONITOR_EARLY_0 or EYE_MONITOR_LATE_0 high in any SAMPLE cycle fails the tap.
  - CLEAR pulses as described.
- Not defined:
  - Eye flags are ignored.
  - EYE_MONITOR_CLEAR_FLAGS_0 is constant 0.
  - The CLEAR state still takes 1 cycle, so timing is identical.

## Test plan
- Data matches only at taps 20..40: 41 up-moves, fail detected at tap 41, 11 down-moves → DONE=1, TAP_OUT=30, FAIL=0.
- Data never matches: sweep ends at tap 127 → FAIL=1, DONE=0, TAP_OUT=127, no down-moves.
- Pass at taps 10..12 only (width 3 < 4): FAIL=1 with TAP_OUT=13.
- Pass from tap 45 with OUT_OF_RANGE asserted at tap 50: first=45, last=50, centre 47, 3 down-moves → DONE, TAP_OUT=47.
- With READ_TRAIN_EYE_MON_EN, data good at taps 20..40 but LATE=1 at tap 35: window 20..34, 8 down-moves from tap 35 → DONE, TAP_OUT=27.
- ARST_N pulsed low at tap 25 mid-SAMPLE: all outputs 0 and state IDLE next cycle; a new START restarts with a LOAD pulse.
